// File: rtl/dynamic_crop.sv
// Runtime-configurable crop and power-of-two decimation for a multi-channel pixel stream.
// Window changes are staged in a pending set and applied only while frame_valid_in is low.
module dynamic_crop #(
    parameter int CHANNELS    = 3,
    parameter int DATA_WIDTH  = 10,
    parameter int COORD_WIDTH = 11
) (
    input  logic                             clock_in,
    input  logic                             reset_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   data_in,
    input  logic                             line_valid_in,
    input  logic                             frame_valid_in,
    input  logic [COORD_WIDTH-1:0]           x_start_in,
    input  logic [COORD_WIDTH-1:0]           x_end_in,
    input  logic [COORD_WIDTH-1:0]           y_start_in,
    input  logic [COORD_WIDTH-1:0]           y_end_in,
    input  logic [1:0]                       skip_in,
    input  logic                             config_valid_in,
    output logic [CHANNELS*DATA_WIDTH-1:0]   data_out,
    output logic                             line_valid_out,
    output logic                             frame_valid_out,
    output logic                             config_error_out,
    output logic [COORD_WIDTH-1:0]           x_size_out,
    output logic [COORD_WIDTH-1:0]           y_size_out
);

    localparam logic [COORD_WIDTH-1:0] COUNT_MAX   = '1;
    localparam logic [COORD_WIDTH-1:0] DEFAULT_END = COORD_WIDTH'(16);
    localparam logic [COORD_WIDTH-1:0] ONE         = COORD_WIDTH'(1);

    // pending register set
    logic [COORD_WIDTH-1:0] pend_x_start_reg, pend_x_end_reg, pend_y_start_reg, pend_y_end_reg;
    logic [1:0]             pend_skip_reg;
    logic                   pend_valid_reg;

    // active register set
    logic [COORD_WIDTH-1:0] act_x_start_reg, act_x_end_reg, act_y_start_reg, act_y_end_reg;
    logic [1:0]             act_skip_reg;

    // counters
    logic [COORD_WIDTH-1:0] x_count_reg, x_count_next;
    logic [COORD_WIDTH-1:0] y_count_reg, y_count_next;
    logic                   prev_line_valid_reg;
    logic                   armed_reg;

    // output registers
    logic [DATA_WIDTH-1:0]  chan_reg [CHANNELS];
    logic                   line_valid_reg, frame_valid_reg, config_error_reg;
    logic [COORD_WIDTH-1:0] x_size_reg, y_size_reg;

    logic                   cfg_bad, cfg_accept, apply_now, keep;
    logic [1:0]             x_phase, y_phase, skip_mask;
    logic [2:0]             pend_round;
    logic [COORD_WIDTH:0]   x_sum, y_sum;
    logic [COORD_WIDTH-1:0] x_size_next, y_size_next;

    assign cfg_bad    = (x_end_in <= x_start_in) || (y_end_in <= y_start_in) || (skip_in == 2'd3);
    assign cfg_accept = config_valid_in && !cfg_bad;
    assign apply_now  = !frame_valid_in && pend_valid_reg;

    // ceil(span / 2^skip) computed from the pending set so sizes move together with the window
    always_comb begin
        pend_round = 3'd0;
        case (pend_skip_reg)
            2'd1:    pend_round = 3'd1;
            2'd2:    pend_round = 3'd3;
            default: pend_round = 3'd0;
        endcase
        x_sum = ({1'b0, pend_x_end_reg} - {1'b0, pend_x_start_reg})
              + {{(COORD_WIDTH-2){1'b0}}, pend_round};
        y_sum = ({1'b0, pend_y_end_reg} - {1'b0, pend_y_start_reg})
              + {{(COORD_WIDTH-2){1'b0}}, pend_round};
        x_size_next = COORD_WIDTH'(x_sum >> pend_skip_reg);
        y_size_next = COORD_WIDTH'(y_sum >> pend_skip_reg);
    end

    // only the two low offset bits matter since skip never exceeds 2
    assign x_phase = 2'(x_count_reg - act_x_start_reg);
    assign y_phase = 2'(y_count_reg - act_y_start_reg);

    always_comb begin
        skip_mask = 2'b00;
        case (act_skip_reg)
            2'd1:    skip_mask = 2'b01;
            2'd2:    skip_mask = 2'b11;
            default: skip_mask = 2'b00;
        endcase
        keep = armed_reg && line_valid_in && frame_valid_in
            && (x_count_reg >= act_x_start_reg) && (x_count_reg < act_x_end_reg)
            && (y_count_reg >= act_y_start_reg) && (y_count_reg < act_y_end_reg)
            && ((x_phase & skip_mask) == 2'b00) && ((y_phase & skip_mask) == 2'b00);
    end

    // counters stay cleared until a frame gap has been seen after reset
    always_comb begin
        x_count_next = '0;
        y_count_next = '0;
        if (armed_reg && line_valid_in)
            x_count_next = (x_count_reg == COUNT_MAX) ? x_count_reg : x_count_reg + ONE;
        if (armed_reg && frame_valid_in) begin
            y_count_next = y_count_reg;
            if (prev_line_valid_reg && !line_valid_in && (y_count_reg != COUNT_MAX))
                y_count_next = y_count_reg + ONE;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            pend_x_start_reg    <= '0;
            pend_x_end_reg      <= DEFAULT_END;
            pend_y_start_reg    <= '0;
            pend_y_end_reg      <= DEFAULT_END;
            pend_skip_reg       <= 2'd0;
            pend_valid_reg      <= 1'b0;
            act_x_start_reg     <= '0;
            act_x_end_reg       <= DEFAULT_END;
            act_y_start_reg     <= '0;
            act_y_end_reg       <= DEFAULT_END;
            act_skip_reg        <= 2'd0;
            x_size_reg          <= DEFAULT_END;
            y_size_reg          <= DEFAULT_END;
            x_count_reg         <= '0;
            y_count_reg         <= '0;
            prev_line_valid_reg <= 1'b0;
            armed_reg           <= 1'b0;
            line_valid_reg      <= 1'b0;
            frame_valid_reg     <= 1'b0;
            config_error_reg    <= 1'b0;
        end else begin
            // apply reads the old pending value; a same-cycle accept overrides pend_valid_reg
            if (apply_now) begin
                act_x_start_reg <= pend_x_start_reg;
                act_x_end_reg   <= pend_x_end_reg;
                act_y_start_reg <= pend_y_start_reg;
                act_y_end_reg   <= pend_y_end_reg;
                act_skip_reg    <= pend_skip_reg;
                x_size_reg      <= x_size_next;
                y_size_reg      <= y_size_next;
                pend_valid_reg  <= 1'b0;
            end
            if (cfg_accept) begin
                pend_x_start_reg <= x_start_in;
                pend_x_end_reg   <= x_end_in;
                pend_y_start_reg <= y_start_in;
                pend_y_end_reg   <= y_end_in;
                pend_skip_reg    <= skip_in;
                pend_valid_reg   <= 1'b1;
            end
            x_count_reg         <= x_count_next;
            y_count_reg         <= y_count_next;
            prev_line_valid_reg <= line_valid_in;
            if (!frame_valid_in)
                armed_reg <= 1'b1;
            line_valid_reg      <= keep;
            frame_valid_reg     <= frame_valid_in;
            config_error_reg    <= config_valid_in && cfg_bad;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            always_ff @(posedge clock_in) begin
                if (reset_in)
                    chan_reg[gi] <= '0;
                else
                    chan_reg[gi] <= data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            end
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = chan_reg[gi];
        end
    endgenerate

    assign line_valid_out   = line_valid_reg;
    assign frame_valid_out  = frame_valid_reg;
    assign config_error_out = config_error_reg;
    assign x_size_out       = x_size_reg;
    assign y_size_out       = y_size_reg;

endmodule

// File: tb/tb_dynamic_crop.sv
// Randomized bench for dynamic_crop: a frame-level window model predicts every output cycle.
module tb_dynamic_crop;

    localparam int CH = 3;
    localparam int DW = 10;
    localparam int CW = 11;

    logic              clock_in = 1'b0;
    logic              reset_in = 1'b0;
    logic [CH*DW-1:0]  data_in = '0;
    logic              line_valid_in = 1'b0;
    logic              frame_valid_in = 1'b0;
    logic [CW-1:0]     x_start_in = '0, x_end_in = '0, y_start_in = '0, y_end_in = '0;
    logic [1:0]        skip_in = '0;
    logic              config_valid_in = 1'b0;
    logic [CH*DW-1:0]  data_out;
    logic              line_valid_out, frame_valid_out, config_error_out;
    logic [CW-1:0]     x_size_out, y_size_out;

    dynamic_crop #(.CHANNELS(CH), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .data_in(data_in),
        .line_valid_in(line_valid_in), .frame_valid_in(frame_valid_in),
        .x_start_in(x_start_in), .x_end_in(x_end_in), .y_start_in(y_start_in), .y_end_in(y_end_in),
        .skip_in(skip_in), .config_valid_in(config_valid_in),
        .data_out(data_out), .line_valid_out(line_valid_out), .frame_valid_out(frame_valid_out),
        .config_error_out(config_error_out), .x_size_out(x_size_out), .y_size_out(y_size_out)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // model: windows as plain integers
    int a_xs = 0, a_xe = 16, a_ys = 0, a_ye = 16, a_sk = 0;
    int p_xs = 0, p_xe = 16, p_ys = 0, p_ye = 16, p_sk = 0;
    bit p_valid = 0;
    bit armed = 0;
    int c_xs = 0, c_xe = 16, c_ys = 0, c_ye = 16, c_sk = 0;
    int frame_kept = 0;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic bit in_win(input int x, input int y);
        int st;
        st = 1 << a_sk;
        return (x >= a_xs) && (x < a_xe) && (y >= a_ys) && (y < a_ye)
            && ((x - a_xs) % st == 0) && ((y - a_ys) % st == 0);
    endfunction

    // number of kept positions along one axis of length lim
    function automatic int axis_count(input int s, input int e, input int lim, input int sk);
        int hi;
        hi = (e < lim) ? e : lim;
        if (hi <= s) return 0;
        return ceil_div(hi - s, 1 << sk);
    endfunction

    task automatic step(input bit lv, input bit fv, input int x, input int y, input bit cfg, input bit rst);
        logic [CH*DW-1:0] d;
        bit keep, err;
        d = {10'($urandom), 10'(y), 10'(x)};
        data_in = d; line_valid_in = lv; frame_valid_in = fv;
        config_valid_in = cfg; reset_in = rst;
        x_start_in = CW'(c_xs); x_end_in = CW'(c_xe);
        y_start_in = CW'(c_ys); y_end_in = CW'(c_ye); skip_in = 2'(c_sk);
        keep = !rst && armed && lv && fv && in_win(x, y);
        err  = !rst && cfg && (c_xe <= c_xs || c_ye <= c_ys || c_sk == 3);
        if (rst) begin
            a_xs = 0; a_xe = 16; a_ys = 0; a_ye = 16; a_sk = 0;
            p_valid = 0; armed = 0;
        end else begin
            if (!fv && p_valid) begin
                a_xs = p_xs; a_xe = p_xe; a_ys = p_ys; a_ye = p_ye; a_sk = p_sk; p_valid = 0;
            end
            if (cfg && !err) begin
                p_xs = c_xs; p_xe = c_xe; p_ys = c_ys; p_ye = c_ye; p_sk = c_sk; p_valid = 1;
            end
            if (!fv) armed = 1;
        end
        @(posedge clock_in);
        #1;
        check_val("line_valid_out", line_valid_out, keep);
        if (keep) check_val("data_out", data_out, d);
        if (rst) check_val("data_out_rst", data_out, 0);
        check_val("frame_valid_out", frame_valid_out, !rst && fv);
        check_val("config_error_out", config_error_out, err);
        check_val("x_size_out", x_size_out, ceil_div(a_xe - a_xs, 1 << a_sk));
        check_val("y_size_out", y_size_out, ceil_div(a_ye - a_ys, 1 << a_sk));
        if (keep) frame_kept++;
        config_valid_in = 1'b0;
        reset_in = 1'b0;
    endtask

    // cfg_line >= 0 strobes c_* on the first blanking cycle of that line
    task automatic run_frame(input int w, input int h, input int hb, input int rst_line, input int cfg_line);
        int exp_kept, eff_h;
        eff_h = (rst_line >= 0) ? rst_line : h;
        exp_kept = axis_count(a_xs, a_xe, w, a_sk) * axis_count(a_ys, a_ye, eff_h, a_sk);
        frame_kept = 0;
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++)
                step(1, 1, x, y, 0, (y == rst_line) && (x == 0));
            for (int b = 0; b < hb; b++)
                step(0, 1, 0, 0, (y == cfg_line) && (b == 0), 0);
        end
        repeat (3 + $urandom_range(0, 3)) step(0, 0, 0, 0, 0, 0);
        check_val("frame_kept", frame_kept, exp_kept);
    endtask

    task automatic cfg_idle(input int xs, input int xe, input int ys, input int ye, input int sk);
        c_xs = xs; c_xe = xe; c_ys = ys; c_ye = ye; c_sk = sk;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);

        run_frame(32, 24, 4, -1, -1);

        cfg_idle(10, 25, 12, 24, 0);
        run_frame(32, 24, 3, -1, -1);
        check_val("kept_10_25_12_24", frame_kept, 180);

        cfg_idle(4, 20, 4, 20, 1);
        check_val("x_size_skip1", x_size_out, 8);
        run_frame(32, 24, 3, -1, -1);
        check_val("kept_skip1", frame_kept, 64);

        // mid-frame request: this frame keeps the old window, the next one uses the new
        c_xs = 2; c_xe = 30; c_ys = 1; c_ye = 9; c_sk = 0;
        run_frame(32, 24, 3, -1, 5);
        run_frame(32, 24, 3, -1, -1);

        cfg_idle(50, 50, 0, 10, 0);
        cfg_idle(0, 10, 0, 10, 3);

        // second strobe lands on the apply cycle of the first
        c_xs = 1; c_xe = 9; c_ys = 2; c_ye = 7; c_sk = 0;
        step(0, 0, 0, 0, 1, 0);
        c_xs = 3; c_xe = 28; c_ys = 0; c_ye = 20; c_sk = 2;
        step(0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        run_frame(32, 24, 2, -1, -1);

        // reset at line 5 discards a pending request and the active window
        cfg_idle(2, 24, 1, 20, 1);
        c_xs = 0; c_xe = 30; c_ys = 0; c_ye = 20; c_sk = 0;
        run_frame(32, 24, 3, 5, 2);
        run_frame(32, 24, 3, -1, -1);

        repeat (16) begin
            int xs, ys;
            xs = $urandom_range(0, 40);
            ys = $urandom_range(0, 30);
            c_xs = xs; c_xe = xs + $urandom_range(0, 30);
            c_ys = ys; c_ye = ys + $urandom_range(0, 24);
            c_sk = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                cfg_idle(c_xs, c_xe, c_ys, c_ye, c_sk);
                run_frame($urandom_range(8, 40), $urandom_range(4, 30), $urandom_range(1, 4), -1, -1);
            end else begin
                run_frame($urandom_range(8, 40), $urandom_range(4, 30), $urandom_range(1, 4),
                          -1, $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
